hazard_tracker: RTL and testbench
=================================

// Module: hazard_tracker
// PURPOSE
//   Producer side of the D-stage hazard interface. Tracks in-flight register writes through E/M/W.
//   Supplies the decoder with reg_addr_E/M/W and Tnew_E/M for its stall and forward decisions.
//   Inserts an E bubble whenever the decoder stalls.
//   Owns the mult/div busy countdown that feeds the decoder's HI/LO stall.
// PARAMETERS
//   ADDR_W       5   register address width
//   MULT_CYCLES  5   busy cycles after a mult/multu start in E
//   DIV_CYCLES   10  busy cycles after a div/divu start in E
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-low; clears all state
//   stall       in   1       decoder stall: hold D, bubble into E
//   dst_addr_D  in   ADDR_W  destination of instr in D; 0 = no write
//   Tnew_D      in   2       Tnew of instr in D, as computed by the decoder
//   md_start_E  in   1       mult/div instr currently in E (start pulse)
//   md_div_E    in   1       1 = div/divu, 0 = mult/multu; valid with md_start_E
//   reg_addr_E  out  ADDR_W  destination held in E
//   reg_addr_M  out  ADDR_W  destination held in M
//   reg_addr_W  out  ADDR_W  destination held in W
//   Tnew_E      out  2       cycles until the E result is available
//   Tnew_M      out  2       cycles until the M result is available
//   md_busy     out  1       HI/LO unit busy or starting this cycle
// BEHAVIOUR
//   Reset (async, reset==0):
//     all reg_addr_*, Tnew_*, the busy counter = 0; md_busy = 0.
//   Each posedge clk with reset==1:
//     E <= stall ? {addr 0, Tnew 0} : {dst_addr_D, Tnew_D}
//     M <= {reg_addr_E, sat_dec(Tnew_E)}
//     W <= reg_addr_M; W carries no Tnew (always 0).
//     sat_dec(x) = (x==0) ? 0 : x-1. Never wraps to 3.
//   Stall handling:
//     - M and W always advance; stall only affects the E load.
//     - Under a stall, the instr already in E still moves to M.
//   Addr 0 rule:
//     - An entry with addr 0 is a no-write; its Tnew is still tracked.
//     - Consumers ignore addr 0, so no special casing is done here.
//   Busy counter (cnt, 4 bits, saturating at 0):
//     - md_start_E & cnt==0  -> cnt <= md_div_E ? DIV_CYCLES : MULT_CYCLES
//     - md_start_E & cnt!=0  -> ignored; the decoder must stall first.
//       Counter keeps decrementing. Assertion in the bench.
//     - otherwise cnt <= sat_dec(cnt)
//     - md_busy = (cnt != 0) | md_start_E  (combinational)
//   Simultaneous events:
//     - stall and md_start_E together: start is still accepted.
//       The md instr is in E, not D.
//   Reset mid-operation:
//     - The counter and every pipeline entry clear immediately, async.
//     - First post-reset edge loads E normally.
//   Latency:
//     - A dst issued at edge k appears in reg_addr_E after k.
//     - It appears in reg_addr_M after k+1 and in reg_addr_W after k+2.
// STRUCTURE
//   Shared package: TNEW_NOW=2'd0, TNEW_1=2'd1, TNEW_2=2'd2; REG_ZERO=5'd0.
//   Shared package also holds the sat_dec function.
//   One sub-module: md_busy_counter (cnt, start/load, md_busy).
//   The E/M/W shift registers stay inline.
// TESTING
//   1. reset=0 mid-run with cnt=7, E=(8,2)
//      -> all outputs 0 the same cycle, before any clk edge.
//   2. lw: dst=9, Tnew_D=2, no stall
//      -> E=(9,2); next cycle M=(9,1); next W=9.
//   3. stall=1 while E=(4,1)
//      -> E=(0,0), M=(4,0); next cycle W=4.
//   4. Tnew_E=0 entering M
//      -> Tnew_M=0 (no wrap); Tnew_E=3 test vector -> Tnew_M=2.
//   5. md_start_E=1, md_div_E=1
//      -> md_busy high 11 cycles (start + 10), then 0.
//      Mult variant: 6 cycles.
//   6. md_start_E while cnt=3
//      -> cnt continues 2,1,0; no reload; bench assertion fires.

Source files
------------

// File: rtl/hazard_tracker_pkg.sv
// Shared constants and helpers for the D-stage hazard interface producer side.
// Tnew encodings, the "no write" register address and saturating decrements.
package hazard_tracker_pkg;

    localparam logic [1:0] TNEW_NOW = 2'd0;
    localparam logic [1:0] TNEW_1   = 2'd1;
    localparam logic [1:0] TNEW_2   = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int CNT_W = 4;

    // Tnew only ever counts down towards "available now"; it must never wrap to 3.
    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == TNEW_NOW) ? TNEW_NOW : x - 2'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec_cnt(input logic [CNT_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_tracker_md_busy_counter.sv
// HI/LO unit busy countdown: loads on an accepted mult/div start in E, then
// decrements to zero; md_busy also covers the start cycle itself.
module md_busy_counter
    import hazard_tracker_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_E,
    input  logic md_div_E,
    output logic md_busy
);

    logic [CNT_W-1:0] cnt;
    logic             start_ok;
    logic [CNT_W-1:0] load_val;

    // A start while still counting is ignored; the decoder is expected to have
    // stalled the instruction in D until the unit drained.
    assign start_ok = md_start_E && (cnt == '0);
    assign load_val = md_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start_ok) begin
            cnt <= load_val;
        end else begin
            cnt <= sat_dec_cnt(cnt);
        end
    end

    assign md_busy = (cnt != '0) || md_start_E;

endmodule

// File: rtl/hazard_tracker.sv
// Tracks in-flight register writes through E/M/W for the decoder's stall and
// forward logic, inserts E bubbles on stall, and owns the mult/div busy timer.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [ADDR_W-1:0] dst_addr_D,
    input  logic [1:0]        Tnew_D,
    input  logic              md_start_E,
    input  logic              md_div_E,
    output logic [ADDR_W-1:0] reg_addr_E,
    output logic [ADDR_W-1:0] reg_addr_M,
    output logic [ADDR_W-1:0] reg_addr_W,
    output logic [1:0]        Tnew_E,
    output logic [1:0]        Tnew_M,
    output logic              md_busy
);

    // Stall only gates the E load; whatever is already in E still advances to M,
    // and M/W shift every cycle. Address 0 entries ride along as no-writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_addr_E <= '0;
            Tnew_E     <= TNEW_NOW;
            reg_addr_M <= '0;
            Tnew_M     <= TNEW_NOW;
            reg_addr_W <= '0;
        end else begin
            if (stall) begin
                reg_addr_E <= ADDR_W'(REG_ZERO);
                Tnew_E     <= TNEW_NOW;
            end else begin
                reg_addr_E <= dst_addr_D;
                Tnew_E     <= Tnew_D;
            end
            reg_addr_M <= reg_addr_E;
            Tnew_M     <= sat_dec(Tnew_E);
            reg_addr_W <= reg_addr_M;
        end
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk        (clk),
        .reset      (reset),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .md_busy    (md_busy)
    );

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed scenarios plus randomized traffic checked
// against a history-queue model of the pipeline and an end-cycle busy model.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic [4:0] dst_addr_D;
    logic [1:0] Tnew_D;
    logic       md_start_E;
    logic       md_div_E;
    logic [4:0] reg_addr_E;
    logic [4:0] reg_addr_M;
    logic [4:0] reg_addr_W;
    logic [1:0] Tnew_E;
    logic [1:0] Tnew_M;
    logic       md_busy;

    hazard_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .dst_addr_D (dst_addr_D),
        .Tnew_D     (Tnew_D),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .reg_addr_E (reg_addr_E),
        .reg_addr_M (reg_addr_M),
        .reg_addr_W (reg_addr_W),
        .Tnew_E     (Tnew_E),
        .Tnew_M     (Tnew_M),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int tnew;
    } ent_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   edge_n = 0;
    int   busy_end = 0;
    int   proto_viol = 0;
    bit   last_busy;
    ent_t pipe_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pipe_q.delete();
        repeat (3) pipe_q.push_front('{addr: 0, tnew: 0});
        busy_end = edge_n;
    endtask

    task automatic check_pipe(input string tag);
        int tm;
        tm = (pipe_q[1].tnew > 0) ? pipe_q[1].tnew - 1 : 0;
        check({tag, ".addr_E"}, reg_addr_E, pipe_q[0].addr);
        check({tag, ".tnew_E"}, Tnew_E, pipe_q[0].tnew);
        check({tag, ".addr_M"}, reg_addr_M, pipe_q[1].addr);
        check({tag, ".tnew_M"}, Tnew_M, tm);
        check({tag, ".addr_W"}, reg_addr_W, pipe_q[2].addr);
    endtask

    // Called just after a falling edge; leaves the bench just after the next one.
    task automatic step(input bit st, input int dst, input int tnew,
                        input bit start, input bit div, input string tag);
        stall      = st;
        dst_addr_D = dst[4:0];
        Tnew_D     = tnew[1:0];
        md_start_E = start;
        md_div_E   = div;
        #1;
        last_busy = md_busy;
        check({tag, ".busy"}, md_busy, ((edge_n < busy_end) || start) ? 1 : 0);
        if (start) begin
            if (edge_n >= busy_end) busy_end = edge_n + 1 + (div ? 10 : 5);
            else proto_viol++;
        end
        @(posedge clk);
        edge_n++;
        pipe_q.push_front(st ? '{addr: 0, tnew: 0} : '{addr: dst, tnew: tnew});
        void'(pipe_q.pop_back());
        @(negedge clk);
        check_pipe(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 0, 0, 1'b0, 1'b0, tag);
    endtask

    task automatic async_reset(input string tag);
        md_start_E = 1'b0;
        #2 reset = 1'b0;
        #1;
        check({tag, ".rst_addr_E"}, reg_addr_E, 0);
        check({tag, ".rst_tnew_E"}, Tnew_E, 0);
        check({tag, ".rst_addr_M"}, reg_addr_M, 0);
        check({tag, ".rst_tnew_M"}, Tnew_M, 0);
        check({tag, ".rst_addr_W"}, reg_addr_W, 0);
        check({tag, ".rst_busy"}, md_busy, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic busy_run(input bit div, input int exp_len, input string tag);
        int n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 0, 0, (i == 0), div, tag);
            if (last_busy) n++;
            else break;
        end
        check({tag, ".len"}, n, exp_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; stall = 1'b0; dst_addr_D = '0; Tnew_D = '0;
        md_start_E = 1'b0; md_div_E = 1'b0;
        #2;
        check("por.addr_E", reg_addr_E, 0);
        check("por.busy", md_busy, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Async reset with the counter at 7 and E holding (8,2).
        step(1'b0, 0, 0, 1'b1, 1'b1, "t1a");
        idle("t1b");
        idle("t1c");
        step(1'b0, 8, 2, 1'b0, 1'b0, "t1d");
        check("t1.E_loaded", reg_addr_E, 8);
        async_reset("t1");
        step(1'b0, 17, 1, 1'b0, 1'b0, "t1post");
        check("t1.post_E", reg_addr_E, 17);

        // Load-use producer flowing E -> M -> W.
        step(1'b0, 9, 2, 1'b0, 1'b0, "t2a");
        check("t2.E", reg_addr_E, 9);
        idle("t2b");
        check("t2.M", reg_addr_M, 9);
        check("t2.TM", Tnew_M, 1);
        idle("t2c");
        check("t2.W", reg_addr_W, 9);

        // Stall bubbles E while the E occupant still advances.
        step(1'b0, 4, 1, 1'b0, 1'b0, "t3a");
        step(1'b1, 11, 2, 1'b0, 1'b0, "t3b");
        check("t3.E_bubble", reg_addr_E, 0);
        check("t3.M", reg_addr_M, 4);
        idle("t3c");
        check("t3.W", reg_addr_W, 4);

        // Tnew saturation into M.
        step(1'b0, 6, 0, 1'b0, 1'b0, "t4a");
        idle("t4b");
        check("t4.TM_zero", Tnew_M, 0);
        step(1'b0, 7, 3, 1'b0, 1'b0, "t4c");
        idle("t4d");
        check("t4.TM_three", Tnew_M, 2);

        // Busy window lengths, plus a start under stall.
        busy_run(1'b1, 11, "t5div");
        busy_run(1'b0, 6, "t5mul");
        step(1'b1, 3, 1, 1'b1, 1'b0, "t5stall");
        repeat (6) idle("t5drain");

        // Start while the counter is at 3 must be ignored.
        step(1'b0, 0, 0, 1'b1, 1'b0, "t6a");
        idle("t6b");
        idle("t6c");
        step(1'b0, 0, 0, 1'b1, 1'b1, "t6viol");
        check("t6.viol_seen", proto_viol, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            idle("t6tail");
            if (last_busy) n++;
            else break;
        end
        check("t6.tail", n, 2);

        // Randomized traffic with one async reset in the middle.
        for (int i = 0; i < 300; i++) begin
            bit st;
            bit go;
            st = ($urandom_range(0, 3) == 0);
            go = (edge_n >= busy_end) && ($urandom_range(0, 5) == 0);
            step(st, $urandom_range(0, 31), $urandom_range(0, 3), go,
                 $urandom_range(0, 1) == 1, "rnd");
            if (i == 150) async_reset("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
